// File: rtl/spi_data_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_data_fifo : show-ahead synchronous FIFO with wrap-bit pointers,
// threshold flags and sticky overflow/underflow.        Rev 1.0
// ---------------------------------------------------------------------------
module spi_data_fifo #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 2,
  parameter int AF_LEVEL  = (1 << ADDRWIDTH) - 1,
  parameter int AE_LEVEL  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [DATAWIDTH-1:0] din,
  input  logic                 wr_en,
  input  logic                 re_en,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDRWIDTH:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << ADDRWIDTH;
  localparam logic [ADDRWIDTH:0] c_af_level = (ADDRWIDTH+1)'(AF_LEVEL);
  localparam logic [ADDRWIDTH:0] c_ae_level = (ADDRWIDTH+1)'(AE_LEVEL);

  logic [DATAWIDTH-1:0] mem_q [DEPTH];
  logic [ADDRWIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDRWIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 w_wr_accept, w_rd_accept;

  // Status is decoded from registered pointers only, so no request-to-output path.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[ADDRWIDTH] != rd_ptr_q[ADDRWIDTH]) &&
                        (wr_ptr_q[ADDRWIDTH-1:0] == rd_ptr_q[ADDRWIDTH-1:0]);
  assign almost_full  = (count >= c_af_level);
  assign almost_empty = (count <= c_ae_level);
  assign dout         = mem_q[rd_ptr_q[ADDRWIDTH-1:0]];
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A full FIFO still takes a write when the same cycle pops a word.
  assign w_rd_accept = re_en && !empty;
  assign w_wr_accept = wr_en && (!full || w_rd_accept);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (w_wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && full && !re_en) overflow_d = 1'b1;
      if (re_en && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Reset scrubs storage so dout reads zero afterwards; a flush does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (w_wr_accept && !clr) begin
      mem_q[wr_ptr_q[ADDRWIDTH-1:0]] <= din;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_data_fifo.sv
`default_nettype none
// tb_spi_data_fifo : queue-model scoreboard plus directed literal checks.
module tb_spi_data_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       wr_en = 1'b0;
  logic       re_en = 1'b0;
  logic [7:0] dout;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  logic       m_fresh = 1'b0;
  logic       started = 1'b0;

  spi_data_fifo #(
    .DATAWIDTH(8),
    .ADDRWIDTH(2),
    .AF_LEVEL (3),
    .AE_LEVEL (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .din         (din),
    .wr_en       (wr_en),
    .re_en       (re_en),
    .dout        (dout),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO as a queue, rules applied at each rising edge.
  always @(posedge clk) begin
    logic do_rd, do_wr, was_full, was_empty;
    if (rst) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_fresh = 1'b1;
      started = 1'b1;
    end else if (clr) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_fresh = 1'b0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      do_rd = re_en && !was_empty;
      do_wr = wr_en && (!was_full || do_rd);
      if (wr_en && was_full && !re_en) m_ovf = 1'b1;
      if (re_en && was_empty) m_udf = 1'b1;
      if (do_rd) void'(mq.pop_front());
      if (do_wr) begin
        mq.push_back(din);
        m_fresh = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_empty", 32'(empty), 32'(mq.size() == 0));
      chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
      chk("m_afull", 32'(almost_full), 32'(mq.size() >= 3));
      chk("m_aempty", 32'(almost_empty), 32'(mq.size() <= 1));
      chk("m_ovf", 32'(overflow), 32'(m_ovf));
      chk("m_udf", 32'(underflow), 32'(m_udf));
      if (mq.size() > 0) chk("m_dout", 32'(dout), 32'(mq[0]));
      else if (m_fresh) chk("m_dout_rst", 32'(dout), 32'h0);
    end
  end

  task automatic step(input logic w, input logic r, input logic c, input logic rs,
                      input logic [7:0] d);
    wr_en = w; re_en = r; clr = c; rst = rs; din = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0; re_en = 1'b0; clr = 1'b0; rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] fill_vals [4];
    logic [7:0] pop_vals [4];
    fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44};

    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_flags", {30'd0, overflow, underflow}, 0);

    // Fill, with threshold checks at every occupancy
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 0, fill_vals[k]);
      chk("thr_count", 32'(count), 32'(k + 1));
      chk("thr_aempty", 32'(almost_empty), 32'((k + 1) <= 1));
      chk("thr_afull", 32'(almost_full), 32'((k + 1) >= 3));
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_dout", 32'(dout), 32'h11);

    step(1, 0, 0, 0, 8'h55);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 4);
    chk("ovf_dout", 32'(dout), 32'h11);

    pop_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      chk("drain_dout", 32'(dout), 32'(pop_vals[k]));
      step(0, 1, 0, 0, 8'h00);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_count", 32'(count), 0);

    step(0, 1, 0, 0, 8'h00);
    chk("udf_flag", 32'(underflow), 1);
    chk("udf_ovf_sticky", 32'(overflow), 1);
    step(0, 0, 1, 0, 8'h00);
    chk("clr_flags", {30'd0, overflow, underflow}, 0);
    chk("clr_empty", 32'(empty), 1);

    // Write+read while full
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 8'(8'hA1 + k));
    step(1, 1, 0, 0, 8'hB5);
    chk("wrfull_count", 32'(count), 4);
    chk("wrfull_dout", 32'(dout), 32'hA2);
    chk("wrfull_ovf", 32'(overflow), 0);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 8'h00);
    chk("wrfull_last", 32'(dout), 32'hB5);
    step(0, 1, 0, 0, 8'h00);

    // Write+read while empty
    step(1, 1, 0, 0, 8'hC1);
    chk("wrempty_count", 32'(count), 1);
    chk("wrempty_udf", 32'(underflow), 1);
    chk("wrempty_dout", 32'(dout), 32'hC1);
    step(1, 0, 1, 0, 8'hC2);
    chk("clr_prio_count", 32'(count), 0);
    chk("clr_prio_udf", 32'(underflow), 0);

    // Pointer wrap at occupancy 2
    step(1, 0, 0, 0, 8'hD0);
    step(1, 0, 0, 0, 8'hD1);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 0, 8'(8'hD2 + i));
      chk("wrap_dout", 32'(dout), 32'(8'(8'hD1 + i)));
      chk("wrap_count", 32'(count), 2);
    end
    step(0, 0, 1, 0, 8'h00);

    // Reset mid-stream with count 3, flags set, and a write pending
    for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 8'(8'hE0 + k));
    step(0, 1, 0, 0, 8'h00);
    chk("pre_rst_count", 32'(count), 3);
    chk("pre_rst_ovf", 32'(overflow), 1);
    step(1, 0, 0, 1, 8'hEE);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_empty", 32'(empty), 1);
    chk("midrst_dout", 32'(dout), 0);
    chk("midrst_flags", {30'd0, overflow, underflow}, 0);

    // Reset while full
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 8'(8'hF0 + k));
    chk("pre_rst_full", 32'(full), 1);
    step(0, 1, 1, 1, 8'h00);
    chk("fullrst_empty", 32'(empty), 1);
    chk("fullrst_dout", 32'(dout), 0);

    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
